// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the writeback arbiter slice.
//   REG_ADDR_W   - register-file address width
//   NREG         - number of architectural registers
//   XLEN_DEFAULT - default datapath width
//   WB_ALU/WB_LOAD/WB_FPU - requester indices into the req_* buses
package wb_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int NREG         = 32;
    localparam int XLEN_DEFAULT = 32;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_FPU  = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NREG-1:0]       reg_mask_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant generator for the writeback port.
//   Build macro WB_RR_EN: defined   -> round-robin, pointer moves past the
//                                      winner whenever advance is high
//                         undefined -> fixed priority, lowest index wins,
//                                      no pointer register
// Ports:
//   clk, rstn   clock and synchronous active-low reset (pointer only)
//   req         per-requester request
//   advance     a grant was consumed this cycle
//   grant       one-hot grant, subset of req
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

`ifdef WB_RR_EN
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;
    int               idx;

    // Scan from the pointer upward, wrapping; first requester seen wins.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    grant[i] = 1'b1;
                    ptr_nxt  = PTR_W'((i + 1) % NREQ);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            ptr <= '0;
        else if (advance)
            ptr <= ptr_nxt;
    end
`else
    logic found;
    logic unused_rr;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Fixed priority is stateless; these inputs exist only for the RR build.
    assign unused_rr = &{1'b0, clk, rstn, advance};
`endif

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates NREQ writeback requesters onto a single registered
// register-file write port and keeps the pending-write scoreboard used by
// decode for issue stalls and operand hazards.
//   Build macro WB_RR_EN selects round-robin arbitration (see rr_arbiter).
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   req_valid/addr/data        per-requester write requests (packed buses)
//   req_ready                  one-hot grant; transfer when valid & ready
//   w_enable/w_addr/w_data     registered register-file write port
//   issue_valid, issue_rd      decode issues an instruction writing issue_rd
//   issue_stall                issue blocked by an outstanding write to rd
//   rs1, rs2, hazard           decode sources, hazard if either is pending
//   pending                    scoreboard, bit n = write to rn outstanding
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NREQ*XLEN-1:0]       req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       w_enable,
    output logic [REG_ADDR_W-1:0]      w_addr,
    output logic [XLEN-1:0]            w_data,
    input  logic                       issue_valid,
    input  logic [REG_ADDR_W-1:0]      issue_rd,
    output logic                       issue_stall,
    input  logic [REG_ADDR_W-1:0]      rs1,
    input  logic [REG_ADDR_W-1:0]      rs2,
    output logic                       hazard,
    output logic [NREG-1:0]            pending
);

    logic [NREQ-1:0] grant;
    logic            transfer;
    reg_addr_t       sel_addr;
    logic [XLEN-1:0] sel_data;
    reg_mask_t       pending_q;
    reg_mask_t       pending_nxt;
    logic            issue_set;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req_valid),
        .advance (transfer),
        .grant   (grant)
    );

    // Holding ready low during reset keeps a waiting request in place.
    assign req_ready = rstn ? grant : '0;
    assign transfer  = |(req_valid & req_ready);

    // Grant is one-hot, so an OR-reduction mux is sufficient.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = sel_addr | req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = sel_data | req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign issue_stall = issue_valid & pending_q[issue_rd] & (issue_rd != '0);
    assign hazard      = pending_q[rs1] | pending_q[rs2];
    assign issue_set   = issue_valid & ~issue_stall & (issue_rd != '0);
    assign pending     = pending_q;

    // Clear happens at the edge where the register file latches w_data; an
    // issue to the same register is already stalled, so order is harmless.
    always_comb begin
        pending_nxt = pending_q;
        if (w_enable)
            pending_nxt[w_addr] = 1'b0;
        if (issue_set)
            pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_enable  <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
            pending_q <= '0;
        end else begin
            // r0 writes are consumed but never reach the register file.
            w_enable  <= transfer && (sel_addr != '0);
            if (transfer) begin
                w_addr <= sel_addr;
                w_data <= sel_data;
            end
            pending_q <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  vld;
    logic [4:0]  a [3];
    logic [31:0] d [3];
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        w_enable;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_stall;
    logic [4:0]  rs1, rs2;
    logic        hazard;
    logic [31:0] pending;

    int n_pass  = 0;
    int n_total = 0;

    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    always #5 clk = ~clk;

    wb_arbiter #(.NREQ(3), .XLEN(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (vld),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .w_enable    (w_enable),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .pending     (pending)
    );

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];

    typedef struct {
        logic [2:0] valid;
        logic [4:0] a0, a1, a2;
        logic [2:0] exp_ready;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called just after a rising edge with inputs already driven: checks the
    // grant, queues the write the next edge must produce, then pops it back.
    task automatic cyc(input logic [2:0] exp_ready, input string name);
        wb_exp_t e, g;
        #2;
        chk($sformatf("%s_ready", name), 64'(req_ready), 64'(exp_ready));
        e.addr = '0;
        e.data = '0;
        for (int i = 0; i < 3; i++)
            if (exp_ready[i]) begin
                e.addr = a[i];
                e.data = d[i];
            end
        e.en = rstn && (exp_ready != 3'b000) && (e.addr != 5'd0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk($sformatf("%s_wen", name), 64'(w_enable), 64'(g.en));
        if (g.en) begin
            chk($sformatf("%s_waddr", name), 64'(w_addr), 64'(g.addr));
            chk($sformatf("%s_wdata", name), 64'(w_data), 64'(g.data));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got running, expected done)");
        $fatal(1);
    end

    initial begin
        rstn        = 1'b0;
        vld         = 3'b111;
        a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        rs1         = 5'd0;
        rs2         = 5'd0;

        vecs[0] = '{3'b000, 5'd1, 5'd2, 5'd3, 3'b000};
        vecs[1] = '{3'b001, 5'd1, 5'd2, 5'd3, 3'b001};
        vecs[2] = '{3'b010, 5'd1, 5'd2, 5'd3, 3'b010};
        vecs[3] = '{3'b100, 5'd1, 5'd2, 5'd3, 3'b100};
        vecs[4] = '{3'b011, 5'd4, 5'd5, 5'd6, 3'b001};
        vecs[5] = '{3'b110, 5'd4, 5'd5, 5'd6, 3'b010};
        vecs[6] = '{3'b101, 5'd8, 5'd9, 5'd10, 3'b001};
        vecs[7] = '{3'b111, 5'd31, 5'd30, 5'd29, 3'b001};
        vecs[8] = '{3'b100, 5'd1, 5'd2, 5'd0, 3'b100};
        vecs[9] = '{3'b010, 5'd1, 5'd0, 5'd3, 3'b010};

        @(posedge clk);
        #1;
        cyc(3'b000, "rst0");
        cyc(3'b000, "rst1");
        chk("rst_waddr", 64'(w_addr), 64'd0);
        chk("rst_wdata", 64'(w_data), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        rstn = 1'b1;

        // Arbitration order with all three requesters valid.
`ifdef WB_RR_EN
        vld = 3'b111; cyc(3'b001, "rr0");
        vld = 3'b111; cyc(3'b010, "rr1");
        vld = 3'b101; cyc(3'b100, "rr2");
        vld = 3'b001; cyc(3'b001, "rr3");
`else
        vld = 3'b111; cyc(3'b001, "fp0");
        vld = 3'b110; cyc(3'b010, "fp1");
        vld = 3'b100; cyc(3'b100, "fp2");
        vld = 3'b000; cyc(3'b000, "fp3");

        for (int v = 0; v < 10; v++) begin
            vld  = vecs[v].valid;
            a[0] = vecs[v].a0;
            a[1] = vecs[v].a1;
            a[2] = vecs[v].a2;
            for (int i = 0; i < 3; i++) d[i] = $urandom;
            cyc(vecs[v].exp_ready, $sformatf("vec%0d", v));
        end
`endif
        vld = 3'b000;
        cyc(3'b000, "idle");

        // Issue r5, ALU writes back r5.
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        chk("iss5_stall", 64'(issue_stall), 64'd0);
        chk("iss5_hazard", 64'(hazard), 64'd0);
        cyc(3'b000, "iss5");
        issue_valid = 1'b0;
        rs1 = 5'd5;
        chk("iss5_pending", 64'(pending), 64'h20);
        #1;
        chk("iss5_hazard_on", 64'(hazard), 64'd1);
        vld = 3'b001; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
        cyc(3'b001, "alu5");
        chk("alu5_pending_held", 64'(pending), 64'h20);
        chk("alu5_hazard_held", 64'(hazard), 64'd1);
        vld = 3'b000;
        cyc(3'b000, "alu5_done");
        chk("alu5_pending_clr", 64'(pending), 64'd0);
        chk("alu5_hazard_clr", 64'(hazard), 64'd0);
        rs1 = 5'd0;

        // Writes to r0 are consumed silently; r0 is never pending.
        vld = 3'b001; a[0] = 5'd0; d[0] = 32'h12345678;
        cyc(3'b001, "addr0");
        vld = 3'b000;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        chk("iss0_stall", 64'(issue_stall), 64'd0);
        cyc(3'b000, "iss0");
        issue_valid = 1'b0;
        chk("iss0_pending", 64'(pending), 64'd0);
        #1;
        chk("rs0_hazard", 64'(hazard), 64'd0);

        // Issue to r7 collides with the writeback clearing r7.
        issue_valid = 1'b1; issue_rd = 5'd7;
        cyc(3'b000, "iss7");
        issue_valid = 1'b0;
        chk("iss7_pending", 64'(pending), 64'h80);
        vld = 3'b001; a[0] = 5'd7; d[0] = $urandom;
        cyc(3'b001, "alu7");
        vld = 3'b000;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        chk("clr7_stall", 64'(issue_stall), 64'd1);
        cyc(3'b000, "clr7");
        chk("clr7_pending", 64'(pending), 64'd0);
        #1;
        chk("retry7_stall", 64'(issue_stall), 64'd0);
        cyc(3'b000, "retry7");
        issue_valid = 1'b0;
        chk("retry7_pending", 64'(pending), 64'h80);

        // Clear r7 and issue r9 at the same edge.
        vld = 3'b001; a[0] = 5'd7; d[0] = $urandom;
        cyc(3'b001, "alu7b");
        vld = 3'b000;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        chk("iss9_stall", 64'(issue_stall), 64'd0);
        cyc(3'b000, "clr7_iss9");
        issue_valid = 1'b0;
        chk("clr7_iss9_pending", 64'(pending), 64'h200);
        rs2 = 5'd9;
        #1;
        chk("rs2_hazard", 64'(hazard), 64'd1);
        vld = 3'b010; a[1] = 5'd9; d[1] = $urandom;
        cyc(3'b010, "ld9");
        vld = 3'b000;
        cyc(3'b000, "ld9_done");
        chk("ld9_pending", 64'(pending), 64'd0);
        rs2 = 5'd0;

        // Reset while a write is in flight and the FPU is waiting.
        vld = 3'b001; a[0] = 5'd6; d[0] = $urandom;
        issue_valid = 1'b1; issue_rd = 5'd10;
        cyc(3'b001, "pre_rst");
        issue_valid = 1'b0;
        chk("pre_rst_pending", 64'(pending), 64'h400);
        rstn = 1'b0;
        vld = 3'b100; a[2] = 5'd4; d[2] = $urandom;
        cyc(3'b000, "in_rst");
        chk("in_rst_waddr", 64'(w_addr), 64'd0);
        chk("in_rst_wdata", 64'(w_data), 64'd0);
        chk("in_rst_pending", 64'(pending), 64'd0);
        rstn = 1'b1;
        cyc(3'b100, "post_rst");
        vld = 3'b000;
        cyc(3'b000, "post_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
